// File: rtl/max_pool_2x2.sv
// Streaming 2x2 / stride-2 max pooling over a raster-order feature map.
// Only one half-row of partial maxima is buffered; there is no frame storage.
module max_pool_2x2 #(
  parameter  int INTEGER_BITS     = 9,
  parameter  int FIXED_POINT_BITS = 4,
  parameter  int IN_WIDTH         = 12,
  parameter  int IN_HEIGHT        = 12,
  localparam int W                = INTEGER_BITS + FIXED_POINT_BITS
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic [W-1:0] conv_output,
  input  logic         conv_output_valid,
  output logic [W-1:0] pool_output,
  output logic         pool_output_valid,
  output logic         frame_done
);

  localparam int CW = (IN_WIDTH > 1) ? $clog2(IN_WIDTH) : 1;
  localparam int RW = (IN_HEIGHT > 1) ? $clog2(IN_HEIGHT) : 1;
  localparam int HW = (IN_WIDTH / 2 > 1) ? $clog2(IN_WIDTH / 2) : 1;
  localparam int LB_DEPTH = IN_WIDTH / 2;

  typedef enum logic {EVEN_ROW = 1'b0, ODD_ROW = 1'b1} row_state_t;

  row_state_t          r_state;
  logic [CW-1:0]       r_col;
  logic [RW-1:0]       r_row;
  logic signed [W-1:0] r_p;
  logic signed [W-1:0] r_lb_rd;
  logic [W-1:0]        r_pool_output;
  logic                r_pool_output_valid;
  logic                r_frame_done;
  logic signed [W-1:0] r_lb [LB_DEPTH];

  logic signed [W-1:0] w_pix;
  logic signed [W-1:0] w_pair_max;
  logic signed [W-1:0] w_win_max;
  logic [HW-1:0]       w_half;
  logic                w_last_col;
  logic                w_last_row;

  assign w_pix      = signed'(conv_output);
  assign w_pair_max = (w_pix > r_p) ? w_pix : r_p;
  // r_lb_rd was fetched on the even-column pixel of this same pair.
  assign w_win_max  = (r_lb_rd > w_pair_max) ? r_lb_rd : w_pair_max;
  assign w_half     = HW'(r_col >> 1);
  assign w_last_col = (r_col == CW'(IN_WIDTH - 1));
  assign w_last_row = (r_row == RW'(IN_HEIGHT - 1));

  // Half-row buffer: store pair maxima on even rows, prefetch on odd rows.
  // The read is registered on the even-column pixel so the value is ready
  // when the matching odd-column pixel arrives, however long the gap.
  always_ff @(posedge i_clk) begin
    if (conv_output_valid) begin
      if (r_col[0] && (r_state == EVEN_ROW)) begin
        r_lb[w_half] <= w_pair_max;
      end
      if (!r_col[0]) begin
        r_lb_rd <= r_lb[w_half];
      end
    end
  end

  // Position counters, row-phase FSM, pair register and registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state             <= EVEN_ROW;
      r_col               <= '0;
      r_row               <= '0;
      r_p                 <= '0;
      r_pool_output       <= '0;
      r_pool_output_valid <= 1'b0;
      r_frame_done        <= 1'b0;
    end else begin
      r_pool_output_valid <= 1'b0;
      r_frame_done        <= 1'b0;
      if (conv_output_valid) begin
        if (w_last_col) begin
          r_col   <= '0;
          r_row   <= w_last_row ? '0 : r_row + RW'(1);
          r_state <= (r_state == EVEN_ROW) ? ODD_ROW : EVEN_ROW;
        end else begin
          r_col <= r_col + CW'(1);
        end

        if (!r_col[0]) begin
          r_p <= w_pix;
        end else if (r_state == ODD_ROW) begin
          r_pool_output       <= w_win_max;
          r_pool_output_valid <= 1'b1;
          r_frame_done        <= w_last_col && w_last_row;
        end
      end
    end
  end

  assign pool_output       = r_pool_output;
  assign pool_output_valid = r_pool_output_valid;
  assign frame_done        = r_frame_done;

endmodule
